mem_bus_master: RTL and testbench
=================================

Name: mem_bus_master

Overview:
Initiator side of the external memory port. Takes load/store/fetch requests from the multicycle datapath over a valid/ready handshake and drives mem_addr/mem_write/mem_wdata into the external memory. Absorbs that memory's one-cycle registered read latency. Adds byte/halfword access, with sign/zero extension on loads and read-modify-write on sub-word stores, because the memory has word-only writes and no byte enables.

Parameters:
WIDTH, 32, data word width (fixed at 32 for lane logic)
ADDR_WIDTH, 16, byte address width; [15:12] selects region (0 ROM, 1 RAM, F I/O)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  master idle, request accepted on valid&ready at posedge
req_write  in  1  1 store, 0 load/fetch
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  sign-extend sub-word loads
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  WIDTH  store data, right-justified (byte [7:0], half [15:0])
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  1  qualifies rsp_valid: request rejected, no memory access
rsp_rdata  out  WIDTH  load result, extended; 0 for stores/errors
mem_write  out  1  write strobe to memory
mem_addr  out  ADDR_WIDTH  word-aligned address ([1:0]=00)
mem_wdata  out  WIDTH  full word to write
mem_rdata  in  WIDTH  memory read data, valid one cycle after mem_addr is presented

Behaviour:
- All outputs are registered. mem_write is never combinational.
- Reset (reset==0 at posedge): state IDLE; mem_write=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - Any in-flight operation is dropped. No write is issued and no response is produced.
- Byte order is big-endian: offset 0 = bits[31:24], offset 3 = bits[7:0]. Half offset 0 = [31:16], offset 2 = [15:0].
- req_ready=1 only in IDLE.
- Error check at accept:
  - Errors: size 11; half with addr[0]=1; word with addr[1:0]!=0; sub-word store to region F.
  - On error: no memory state entered, mem outputs unchanged. rsp_valid=1, rsp_err=1 and rsp_rdata=0 in the next cycle. Stay IDLE.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR, RMW_ADDR, RMW_DATA, RMW_WR.
- Accept edge k: mem_addr is loaded with {req_addr[15:2],2'b00}; offset, size, signed and data are latched.
  - Load -> RD_ADDR. Word store -> WR. Sub-word store -> RMW_ADDR.
- Load path:
  - RD_ADDR: one cycle, mem_write=0.
  - RD_DATA: mem_rdata is valid. At the exit edge, rsp_rdata is loaded with the extracted and extended lane, rsp_valid=1, next state IDLE.
  - rsp_valid is sampled high at edge k+3.
- Word store path:
  - WR: mem_write=1 and mem_wdata=req_wdata for exactly one cycle.
  - rsp_valid is sampled high at edge k+2, rsp_rdata=0.
- Sub-word store path:
  - RMW_ADDR: read as above.
  - RMW_DATA: merge the latched byte/half into mem_rdata at the lane and load the result into mem_wdata.
  - RMW_WR: mem_write=1 for one cycle, same mem_addr.
  - rsp_valid is sampled high at edge k+4.
- rsp_valid lasts exactly one cycle. It coincides with IDLE, so a new request is accepted in the same cycle (back-to-back, no bubble).
- A read issued after a write to the same word sees the new data: the write edge precedes the read address cycle.
- Reset released mid-stream: first accept is possible at the first posedge with reset==1.

Decomposition:
- Package mem_bus_pkg holds:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD.
  - region codes RGN_ROM=4'h0, RGN_RAM=4'h1, RGN_IO=4'hF.
  - FSM state enum.
  - big-endian lane offset helpers.
- One combinational sub-module, mem_lane_unit: load extract + extend, and store merge. Inputs: word, offset, size, signed, store data.

Test Plan:
- RAM[0x1000]=0xDEADBEEF; word load 0x1000 at edge k -> rsp_valid@k+3, rsp_rdata=0xDEADBEEF, rsp_err=0, mem_write never 1.
- Byte load 0x1001: signed -> 0xFFFFFFAD, unsigned -> 0x000000AD. Half load 0x1002 signed -> 0xFFFFBEEF.
- Byte store 0x1003, wdata 0x00000011 -> mem_write high exactly one cycle with mem_addr=0x1000, mem_wdata=0xDEADBE11; rsp_valid@k+4. Then word load 0x1000 -> 0xDEADBE11.
- Word load 0x1002 and half store 0xF001 -> rsp_err=1 @k+1, rsp_rdata=0, no mem_write, mem_addr unchanged.
- Sub-word store accepted, reset=0 asserted during RMW_DATA -> mem_write stays 0, no rsp_valid, all outputs 0. req_ready=1 the cycle after reset=1.
- Word store 0x1004=0x12345678, load 0x1004 accepted in the store's rsp_valid cycle -> rsp_rdata=0x12345678 three edges later.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared codes for the external memory port: access sizes, address regions,
// master FSM states and big-endian lane shift helpers.
package mem_bus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] RGN_ROM = 4'h0;
  localparam logic [3:0] RGN_RAM = 4'h1;
  localparam logic [3:0] RGN_IO  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR,
    ST_RMW_ADDR,
    ST_RMW_DATA,
    ST_RMW_WR
  } state_t;

  // Big-endian: byte offset 0 lives in bits [31:24], so shift = (3 - off) * 8.
  function automatic logic [4:0] byte_shift(input logic [1:0] off);
    return {~off, 3'b000};
  endfunction

  // Half offset 0 lives in bits [31:16], offset 2 in [15:0].
  function automatic logic [4:0] half_shift(input logic off_hi);
    return {~off_hi, 4'b0000};
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: extracts/extends sub-word loads and merges
// sub-word store data into a read word for read-modify-write.
module mem_lane_unit
  import mem_bus_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged
);

  logic [4:0]  w_bsh;
  logic [4:0]  w_hsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_bsh  = byte_shift(i_offset);
  assign w_hsh  = half_shift(i_offset[1]);
  assign w_byte = 8'(i_word >> w_bsh);
  assign w_half = 16'(i_word >> w_hsh);

  always_comb begin
    o_rdata  = i_word;
    o_merged = i_word;
    case (i_size)
      SZ_BYTE: begin
        o_rdata  = {{24{i_signed & w_byte[7]}}, w_byte};
        o_merged = (i_word & ~(32'h0000_00FF << w_bsh)) | ({24'b0, i_wdata[7:0]} << w_bsh);
      end
      SZ_HALF: begin
        o_rdata  = {{16{i_signed & w_half[15]}}, w_half};
        o_merged = (i_word & ~(32'h0000_FFFF << w_hsh)) | ({16'b0, i_wdata} << w_hsh);
      end
      default: begin
        o_rdata  = i_word;
        o_merged = i_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_bus_master.sv
// Initiator for the word-only external memory: absorbs the one-cycle read
// latency and adds byte/half loads (extended) and stores (read-modify-write).
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_signed,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [WIDTH-1:0]      i_req_wdata,
  output logic                  o_rsp_valid,
  output logic                  o_rsp_err,
  output logic [WIDTH-1:0]      o_rsp_rdata,
  output logic                  o_mem_write,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0]      o_mem_wdata,
  input  logic [WIDTH-1:0]      i_mem_rdata
);

  state_t                r_state, w_state_next;
  logic                  r_mem_write, w_mem_write_next;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_next;
  logic [WIDTH-1:0]      r_mem_wdata, w_mem_wdata_next;
  logic                  r_rsp_valid, w_rsp_valid_next;
  logic                  r_rsp_err, w_rsp_err_next;
  logic [WIDTH-1:0]      r_rsp_rdata, w_rsp_rdata_next;
  logic [1:0]            r_offset, w_offset_next;
  logic [1:0]            r_size, w_size_next;
  logic                  r_signed, w_signed_next;
  logic [15:0]           r_wdata, w_wdata_next;

  logic                  w_accept;
  logic                  w_req_err;
  logic [WIDTH-1:0]      w_lane_rdata;
  logic [WIDTH-1:0]      w_lane_merged;

  mem_lane_unit u_lane (
    .i_word   (i_mem_rdata),
    .i_offset (r_offset),
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_wdata  (r_wdata),
    .o_rdata  (w_lane_rdata),
    .o_merged (w_lane_merged)
  );

  assign w_accept = i_req_valid && (r_state == ST_IDLE);

  // Requests the memory cannot honour; sub-word RMW to I/O would cause side-effect reads.
  always_comb begin
    w_req_err = 1'b0;
    case (i_req_size)
      SZ_BYTE: w_req_err = i_req_write && (i_req_addr[ADDR_WIDTH-1 -: 4] == RGN_IO);
      SZ_HALF: w_req_err = i_req_addr[0] ||
                           (i_req_write && (i_req_addr[ADDR_WIDTH-1 -: 4] == RGN_IO));
      SZ_WORD: w_req_err = (i_req_addr[1:0] != 2'b00);
      default: w_req_err = 1'b1;
    endcase
  end

  always_comb begin
    w_state_next     = r_state;
    w_mem_write_next = 1'b0;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_rsp_valid_next = 1'b0;
    w_rsp_err_next   = 1'b0;
    w_rsp_rdata_next = '0;
    w_offset_next    = r_offset;
    w_size_next      = r_size;
    w_signed_next    = r_signed;
    w_wdata_next     = r_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_req_err) begin
            w_rsp_valid_next = 1'b1;
            w_rsp_err_next   = 1'b1;
          end else begin
            w_mem_addr_next = {i_req_addr[ADDR_WIDTH-1:2], 2'b00};
            w_offset_next   = i_req_addr[1:0];
            w_size_next     = i_req_size;
            w_signed_next   = i_req_signed;
            w_wdata_next    = i_req_wdata[15:0];
            if (!i_req_write) begin
              w_state_next = ST_RD_ADDR;
            end else if (i_req_size == SZ_WORD) begin
              w_state_next     = ST_WR;
              w_mem_write_next = 1'b1;
              w_mem_wdata_next = i_req_wdata;
            end else begin
              w_state_next = ST_RMW_ADDR;
            end
          end
        end
      end
      ST_RD_ADDR:  w_state_next = ST_RD_DATA;
      ST_RD_DATA: begin
        w_rsp_valid_next = 1'b1;
        w_rsp_rdata_next = w_lane_rdata;
        w_state_next     = ST_IDLE;
      end
      ST_WR: begin
        w_rsp_valid_next = 1'b1;
        w_state_next     = ST_IDLE;
      end
      ST_RMW_ADDR: w_state_next = ST_RMW_DATA;
      ST_RMW_DATA: begin
        w_mem_wdata_next = w_lane_merged;
        w_mem_write_next = 1'b1;
        w_state_next     = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        w_rsp_valid_next = 1'b1;
        w_state_next     = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_offset    <= '0;
      r_size      <= '0;
      r_signed    <= 1'b0;
      r_wdata     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_mem_write <= w_mem_write_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_err   <= w_rsp_err_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_offset    <= w_offset_next;
      r_size      <= w_size_next;
      r_signed    <= w_signed_next;
      r_wdata     <= w_wdata_next;
    end
  end

  assign o_req_ready = (r_state == ST_IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_mem_write = r_mem_write;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_bus_master.sv
// Randomized scoreboard bench for mem_bus_master with a word-addressed memory
// model and an independent byte-level reference of memory contents.
module tb_mem_bus_master;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, mem_write;
  logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;

  always #5 clk = ~clk;

  mem_bus_master #(.WIDTH(32), .ADDR_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
    .i_req_size(req_size), .i_req_signed(req_signed), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_rsp_valid(rsp_valid), .o_rsp_err(rsp_err),
    .o_rsp_rdata(rsp_rdata), .o_mem_write(mem_write), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // External memory: word-only writes, registered read
  logic [31:0] dev_mem [0:16383];
  logic [31:0] ref_mem [0:16383];
  always @(posedge clk) begin
    if (mem_write) dev_mem[mem_addr[15:2]] <= mem_wdata;
    mem_rdata <= dev_mem[mem_addr[15:2]];
  end

  typedef struct { logic err; logic [31:0] rdata; int exp_cyc; logic [15:0] addr; } rsp_t;
  typedef struct { logic [15:0] addr; logic [31:0] data; } wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] ref_last_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: consumes expected responses/writes whenever the DUT presents them
  always @(negedge clk) begin
    if (reset) begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_latency", 32'(cyc), 32'(e.exp_cyc));
          check("mem_addr_at_rsp", {16'b0, mem_addr}, {16'b0, e.addr});
          $display("rsp  cyc=%0d err=%0d rdata=%h mem_addr=%h", cyc, rsp_err, rsp_rdata, mem_addr);
        end
      end
      if (mem_write) begin
        if (wr_q.size() == 0) begin
          check("unexpected_mem_write", 32'd1, 32'd0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check("mem_write_addr", {16'b0, mem_addr}, {16'b0, w.addr});
          check("mem_write_data", mem_wdata, w.data);
          $display("wr   cyc=%0d addr=%h data=%h", cyc, mem_addr, mem_wdata);
        end
      end
    end
  end

  // Drive one request; when commit is set the reference model predicts its outcome.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [15:0] addr, input logic [31:0] wd, input bit commit);
    int guard = 0;
    int k, sh;
    logic err;
    logic [31:0] word, mask, val;
    rsp_t e;
    wr_t w;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_before_issue", {31'b0, req_ready}, 32'd1);
    if (!req_ready) return;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    k = cyc + 1;
    err = (sz == 2'b11) || (sz == SZ_HALF && addr[0]) ||
          (sz == SZ_WORD && addr[1:0] != 2'b00) ||
          (wr && sz != SZ_WORD && addr[15:12] == RGN_IO);
    word = ref_mem[addr[15:2]];
    mask = (sz == SZ_BYTE) ? 32'hFF : 32'hFFFF;
    sh   = (sz == SZ_BYTE) ? (3 - int'(addr[1:0])) * 8 : (2 - int'(addr[1:0])) * 8;
    if (commit) begin
      e.err = err; e.rdata = '0;
      if (err) begin
        e.exp_cyc = k;
        e.addr = ref_last_addr;
      end else begin
        ref_last_addr = {addr[15:2], 2'b00};
        e.addr = ref_last_addr;
        if (!wr) begin
          e.exp_cyc = k + 2;
          if (sz == SZ_WORD) begin
            e.rdata = word;
          end else begin
            val = (word >> sh) & mask;
            if (sg && ((sz == SZ_BYTE && val[7]) || (sz == SZ_HALF && val[15])))
              val = val | ~mask;
            e.rdata = val;
          end
        end else begin
          w.addr = ref_last_addr;
          if (sz == SZ_WORD) begin
            e.exp_cyc = k + 1;
            w.data = wd;
          end else begin
            e.exp_cyc = k + 3;
            w.data = (word & ~(mask << sh)) | ((wd & mask) << sh);
          end
          ref_mem[addr[15:2]] = w.data;
          wr_q.push_back(w);
        end
      end
      rsp_q.push_back(e);
    end
    $display("req  cyc=%0d wr=%0d size=%0d signed=%0d addr=%h wdata=%h", k, wr, sz, sg, addr, wd);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", 32'(rsp_q.size() + wr_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_rsp_err"},   {31'b0, rsp_err},   32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_mem_write"}, {31'b0, mem_write}, 32'd0);
    check({tag, "_mem_addr"},  {16'b0, mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [3:0] rgn;
    logic [15:0] a;
    for (int i = 0; i < 16384; i++) begin
      ref_mem[i] = $urandom;
      dev_mem[i] = ref_mem[i];
    end
    ref_mem[16'h1000 >> 2] = 32'hDEADBEEF;
    dev_mem[16'h1000 >> 2] = 32'hDEADBEEF;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;

    // Directed scenarios
    issue(1'b0, SZ_WORD, 1'b0, 16'h1000, 32'h0, 1'b1);
    issue(1'b0, SZ_BYTE, 1'b1, 16'h1001, 32'h0, 1'b1);
    issue(1'b0, SZ_BYTE, 1'b0, 16'h1001, 32'h0, 1'b1);
    issue(1'b0, SZ_HALF, 1'b1, 16'h1002, 32'h0, 1'b1);
    issue(1'b1, SZ_BYTE, 1'b0, 16'h1003, 32'h00000011, 1'b1);
    issue(1'b0, SZ_WORD, 1'b0, 16'h1000, 32'h0, 1'b1);
    issue(1'b0, SZ_WORD, 1'b0, 16'h1002, 32'h0, 1'b1);
    issue(1'b1, SZ_HALF, 1'b0, 16'hF001, 32'h0000ABCD, 1'b1);
    issue(1'b1, SZ_BYTE, 1'b0, 16'hF002, 32'h00000055, 1'b1);
    issue(1'b0, SZ_HALF, 1'b0, 16'h1003, 32'h0, 1'b1);
    issue(1'b1, 2'b11,   1'b0, 16'h1000, 32'h0, 1'b1);
    issue(1'b1, SZ_WORD, 1'b0, 16'h1004, 32'h12345678, 1'b1);
    issue(1'b0, SZ_WORD, 1'b0, 16'h1004, 32'h0, 1'b1);
    drain();

    // Reset during RMW_DATA drops the store entirely
    issue(1'b1, SZ_BYTE, 1'b0, 16'h1005, 32'h000000AA, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ref_last_addr = '0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");
    issue(1'b0, SZ_WORD, 1'b0, 16'h1004, 32'h0, 1'b1);
    issue(1'b0, SZ_BYTE, 1'b0, 16'h1005, 32'h0, 1'b1);

    // Randomized traffic over a few words in each region
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 2))
        0: rgn = RGN_ROM;
        1: rgn = RGN_RAM;
        default: rgn = RGN_IO;
      endcase
      a = {rgn, 7'b0, 5'($urandom_range(0, 31))};
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom, 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
